// File: rtl/seq_pkg.sv
// Shared definitions for the PISO serializer: FSM state encoding and frame length.
// Optional feature macro: PISO_SERIALIZER_PARITY_EN (appends an even-parity bit).
package seq_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Number of serial bit cycles in one frame for a given data width.
    function automatic int frame_len(input int width);
`ifdef PISO_SERIALIZER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable up-counter with registered terminal-count flag for the PISO serializer.
// Counts 1..MAX_COUNT and saturates there; clear returns it to 0.
// Optional feature macro: PISO_SERIALIZER_PARITY_EN (exposes the count value).
module piso_bit_counter #(
    parameter int MAX_COUNT = 8,
    parameter int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          en_i,
    input  logic          clr_i,
`ifdef PISO_SERIALIZER_PARITY_EN
    output logic [CW-1:0] cnt_o,
`endif
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tc_q;
    logic          tc_d;

    // Next count: load to 1 has priority, then clear, then saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = tc_q;
        if (load_i) begin
            cnt_d = {{(CW-1){1'b0}}, 1'b1};
            tc_d  = ({{(CW-1){1'b0}}, 1'b1} == CW'(MAX_COUNT));
        end else if (clr_i) begin
            cnt_d = {CW{1'b0}};
            tc_d  = 1'b0;
        end else if (en_i && !tc_q) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            tc_d  = ((cnt_q + {{(CW-1){1'b0}}, 1'b1}) == CW'(MAX_COUNT));
        end else begin
            cnt_d = cnt_q;
            tc_d  = tc_q;
        end
    end

    // Count and terminal-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

`ifdef PISO_SERIALIZER_PARITY_EN
    assign cnt_o = cnt_q;
`endif
    assign tc_o = tc_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load handshake.
// The accept edge registers the first bit; a new word can be accepted in the
// last bit cycle so frames run back-to-back without an idle gap.
// Optional feature macro: PISO_SERIALIZER_PARITY_EN (even-parity bit after data).
module piso_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int CW        = $clog2(FRAME_LEN + 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             dout_q;
    logic             dout_d;
    logic             dout_valid_q;
    logic             dout_valid_d;
    logic             frame_start_q;
    logic             frame_start_d;
    logic             cnt_load_s;
    logic             cnt_en_s;
    logic             cnt_clr_s;
    logic             done_s;
    logic             accept_s;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             parity_q;
    logic             parity_d;
    logic [CW-1:0]    cnt_s;
`endif

    piso_bit_counter #(
        .MAX_COUNT (FRAME_LEN),
        .CW        (CW)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load_s),
        .en_i   (cnt_en_s),
        .clr_i  (cnt_clr_s),
`ifdef PISO_SERIALIZER_PARITY_EN
        .cnt_o  (cnt_s),
`endif
        .tc_o   (done_s)
    );

    assign load_ready = (state_q == ST_IDLE) || done_s;
    assign accept_s   = load_valid && load_ready;

    // Next-state, shift-register and output-bit selection.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        dout_d        = 1'b0;
        dout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        cnt_load_s    = 1'b0;
        cnt_en_s      = 1'b0;
        cnt_clr_s     = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
        parity_d      = parity_q;
`endif
        if (accept_s) begin
            // Same path for a word from IDLE and for one taken on the done edge.
            state_d       = ST_SHIFT;
            dout_valid_d  = 1'b1;
            frame_start_d = 1'b1;
            cnt_load_s    = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_d      = ^din;
`endif
            if (MSB_FIRST) begin
                dout_d  = din[WIDTH-1];
                shreg_d = din << 1;
            end else begin
                dout_d  = din[0];
                shreg_d = din >> 1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (done_s) begin
                        state_d   = ST_IDLE;
                        cnt_clr_s = 1'b1;
                        shreg_d   = {WIDTH{1'b0}};
                    end else begin
                        dout_valid_d = 1'b1;
                        cnt_en_s     = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
                        if (cnt_s == CW'(WIDTH)) begin
                            dout_d = parity_q;
                        end else
`endif
                        if (MSB_FIRST) begin
                            dout_d  = shreg_q[WIDTH-1];
                            shreg_d = shreg_q << 1;
                        end else begin
                            dout_d  = shreg_q[0];
                            shreg_d = shreg_q >> 1;
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    cnt_clr_s = 1'b1;
                    shreg_d   = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // State, shift register and registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            shreg_q       <= {WIDTH{1'b0}};
            dout_q        <= 1'b0;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef PISO_SERIALIZER_PARITY_EN
    // Parity of the accepted word, held for the trailing parity cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign frame_start = frame_start_q;
    assign done        = done_s;

endmodule
